// File: rtl/frame_pkg.sv
// Shared types and widths for the frame tick receiver.
package frame_pkg;

  localparam int unsigned TMO_W  = 20;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned EDGE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } frame_state_e;

  // Width of a counter holding 0..div-1, never narrower than one bit.
  function automatic int unsigned step_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer and rising-edge detector for the slow frame clock.
// With FRAME_RX_GLITCH_FILTER_EN defined, an edge is accepted only after
// the synchronized level has been high for three clocks following a low.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic slow_in,
  output logic edge_det
);

`ifdef FRAME_RX_GLITCH_FILTER_EN
  localparam int unsigned HIST_W = 3;
`else
  localparam int unsigned HIST_W = 1;
`endif

  logic [1:0]        sync_q;
  logic [HIST_W-1:0] hist_q;
  logic              rise_c;

  // Rising edge qualification on the synchronized level and its history.
  always_comb begin
`ifdef FRAME_RX_GLITCH_FILTER_EN
    rise_c = sync_q[1] & hist_q[0] & hist_q[1] & ~hist_q[2];
`else
    rise_c = sync_q[1] & ~hist_q[0];
`endif
  end

  // Two-flop synchronizer, level history and registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      hist_q   <= '0;
      edge_det <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], slow_in};
`ifdef FRAME_RX_GLITCH_FILTER_EN
      hist_q   <= {hist_q[1:0], sync_q[1]};
`else
      hist_q   <= sync_q[1];
`endif
      edge_det <= rise_c;
    end
  end

endmodule

// File: rtl/frame_tick_rx.sv
// Frame tick receiver: locks onto a slow divided clock, emits one frame_tick
// per accepted edge while locked, a step_tick every DIV frames, and flags loss.
// Optional glitch filter in edge_sync: define FRAME_RX_GLITCH_FILTER_EN.
module frame_tick_rx
  import frame_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 140000,
  parameter int unsigned LOCK_EDGES = 2,
  parameter int unsigned DIV        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  input  logic             en,
  output logic             frame_tick,
  output logic             step_tick,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned       STEP_W    = step_w(DIV);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] LOCK_N    = EDGE_W'(LOCK_EDGES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DIV - 1);

  frame_state_e      state_q, state_n;
  logic [TMO_W-1:0]  tmo_q, tmo_n;
  logic [EDGE_W-1:0] edges_q, edges_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              lost_n;
  logic              tick_c;
  logic              step_c;
  logic              timeout_c;
  logic              edge_det;

  edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .slow_in  (slow_in),
    .edge_det (edge_det)
  );

  // Next-state, timeout, counter and tick decisions; an edge beats a timeout.
  always_comb begin
    state_n   = state_q;
    tmo_n     = tmo_q;
    edges_n   = edges_q;
    step_n    = step_q;
    cnt_n     = frame_cnt;
    lost_n    = lost;
    tick_c    = 1'b0;
    step_c    = 1'b0;
    timeout_c = !edge_det && (tmo_q == TMO_LAST);

    if (edge_det) begin
      tmo_n = '0;
    end else if (tmo_q < TMO_MAX) begin
      tmo_n = tmo_q + TMO_W'(1);
    end

    case (state_q)
      IDLE, LOST: begin
        if (edge_det) begin
          if (LOCK_N <= EDGE_W'(1)) begin
            state_n = LOCKED;
            edges_n = '0;
            lost_n  = 1'b0;
          end else begin
            state_n = LOCKING;
            edges_n = EDGE_W'(1);
          end
        end
      end
      LOCKING: begin
        if (edge_det) begin
          if ((edges_q + EDGE_W'(1)) >= LOCK_N) begin
            state_n = LOCKED;
            edges_n = '0;
            lost_n  = 1'b0;
          end else begin
            edges_n = edges_q + EDGE_W'(1);
          end
        end else if (timeout_c) begin
          state_n = IDLE;
          edges_n = '0;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          tick_c = en;
        end else if (timeout_c) begin
          state_n = LOST;
          lost_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (tick_c) begin
      cnt_n = frame_cnt + CNT_W'(1);
      if (step_q == STEP_LAST) begin
        step_n = '0;
        step_c = 1'b1;
      end else begin
        step_n = step_q + STEP_W'(1);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      edges_q    <= '0;
      step_q     <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      step_tick  <= 1'b0;
      locked     <= 1'b0;
      lost       <= 1'b0;
    end else begin
      state_q    <= state_n;
      tmo_q      <= tmo_n;
      edges_q    <= edges_n;
      step_q     <= step_n;
      frame_cnt  <= cnt_n;
      frame_tick <= tick_c;
      step_tick  <= step_c;
      locked     <= (state_n == LOCKED);
      lost       <= lost_n;
    end
  end

endmodule

// File: doc/frame_tick_rx.md
FRAME_TICK_RX -- requirements
Module: frame_tick_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 140000, meaning the max clk cycles allowed between accepted slow_in rising edges before loss is declared.
REQ-002 SHALL have parameter LOCK_EDGES, default 2, meaning the number of consecutive in-time edges required to lock.
REQ-003 SHALL have parameter DIV, default 4, meaning the number of frame_tick pulses per step_tick.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port slow_in  input  1  divided square-wave clock from the frame divider, treated as asynchronous data.
REQ-007 SHALL have port en  input  1  tick gate; low pauses frame_tick, step_tick and frame_cnt.
REQ-008 SHALL have port frame_tick  output  1  one-clk pulse per accepted slow_in rising edge while LOCKED and en.
REQ-009 SHALL have port step_tick  output  1  one-clk pulse coincident with every DIV-th frame_tick.
REQ-010 SHALL have port frame_cnt  output  16  count of emitted frame_ticks.
REQ-011 SHALL have port locked  output  1  high in LOCKED.
REQ-012 SHALL have port lost  output  1  sticky; high from timeout in LOCKED until the next lock.

Function
REQ-013 SHALL pass slow_in through a 2-flop synchronizer, then detect rising edges against a third registered sample.
REQ-014 SHALL assert frame_tick exactly 3 clk cycles after the first clk edge that samples slow_in high (filter off).
REQ-015 SHALL run the FSM IDLE -> LOCKING on the first detected edge after reset.
REQ-016 SHALL, in LOCKING, count in-time edges; reaching LOCK_EDGES SHALL move to LOCKED; a timeout SHALL clear the count and return to IDLE.
REQ-017 SHALL, in LOCKED, move to LOST when the timeout counter reaches TIMEOUT with no edge; LOST SHALL move to LOCKING on the next edge, with the edge count starting at 1.
REQ-018 SHALL clear the 20-bit timeout counter on each detected edge and saturate it at TIMEOUT.
REQ-019 SHALL emit frame_tick only in LOCKED with en high; the edge that completes locking SHALL NOT tick.
REQ-020 SHALL increment frame_cnt on each frame_tick, wrapping 0xFFFF -> 0x0000.
REQ-021 SHALL use a step counter 0..DIV-1 advancing on each frame_tick; step_tick SHALL fire when the counter wraps from DIV-1 to 0.
REQ-022 SHALL, when an edge and a timeout coincide on one cycle, treat the edge as winning: no transition to LOST.
REQ-023 SHALL, with en low, keep tracking edges, lock state and timeout; only the ticks and counters freeze.

Reset
REQ-024 SHALL, on rst high at a clk edge, set the FSM to IDLE, clear the synchronizer, timeout, edge and step counters, and set frame_cnt=0 and frame_tick=step_tick=locked=lost=0.
REQ-025 SHALL, on rst asserted mid-frame, drop any pending tick; no tick SHALL appear in the cycle following reset release.

Configuration
REQ-026 SHALL, with FRAME_RX_GLITCH_FILTER_EN defined, accept a rising edge only after the synchronized level holds high for 3 consecutive clks after a low; frame_tick latency then becomes 5 clks.
REQ-027 SHALL, without FRAME_RX_GLITCH_FILTER_EN, accept any single-cycle low-to-high transition at the synchronizer output.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, LOCKING, LOCKED, LOST) and the counter-width constants in the shared package frame_pkg.
REQ-029 SHALL implement the synchronizer, optional filter and edge detect as sub-module edge_sync; the FSM and counters SHALL live in frame_tick_rx.

Verification
REQ-030 SHALL cover lock: TIMEOUT=40, slow_in period 20 clks -> locked rises on the 2nd edge; the 3rd edge yields frame_tick 3 clks after sampling.
REQ-031 SHALL cover loss: stop slow_in after lock -> locked=0 and lost=1 exactly 40 clks after the last edge; the next two edges relock and clear lost.
REQ-032 SHALL cover division: DIV=4, 12 locked edges -> frame_cnt=12 and step_tick on the 4th, 8th and 12th frame_tick.
REQ-033 SHALL cover wrap and pause: preload via 65536 ticks -> frame_cnt=0; en=0 for 3 edges -> frame_cnt unchanged and locked stays 1.
REQ-034 SHALL cover the filter: with FRAME_RX_GLITCH_FILTER_EN, a 1-clk high glitch -> no edge accepted; a 3-clk high -> accepted with 5-clk latency.
REQ-035 SHALL cover reset mid-operation: rst pulse 1 clk after an edge in LOCKED -> no frame_tick, state IDLE, all outputs 0.
